// File: rtl/mapreduce_pkg.sv
// Shared types and constants for the reduce crossbar senders.
// Key width, sender state encoding and beat counter width helper.
package mapreduce_pkg;

  localparam int KEY_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } sender_state_e;

  function automatic int beat_width(input int dim);
    return $clog2(dim) + 1;
  endfunction

endpackage

// File: rtl/point_fifo.sv
// Synchronous point FIFO; head data is combinational.
// Ports: clock, reset, i_push/i_data, i_pop, o_data, o_full, o_empty, o_count.
module point_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/partition_sender.sv
// Buffers partitioner points, requests the reduce arbiter, then
// serialises each granted point onto the crossbar lane one dimension per cycle.
// Ports: clock/reset, point push (valid/ready/key/value), o_request/
// i_acknowledged, lane outputs o_key_data/o_value_data, o_count, o_busy.
module partition_sender
  import mapreduce_pkg::*;
#(
  parameter int PRECISION = 16,
  parameter int DIMENSION = 2,
  parameter int DEPTH     = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_point_valid,
  output logic                           o_point_ready,
  input  logic [KEY_WIDTH-1:0]           i_point_key,
  input  logic [PRECISION*DIMENSION-1:0] i_point_value,
  output logic                           o_request,
  input  logic                           i_acknowledged,
  output logic [KEY_WIDTH-1:0]           o_key_data,
  output logic [PRECISION-1:0]           o_value_data,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic                           o_busy
);

  localparam int VW = PRECISION * DIMENSION;
  localparam int BW = beat_width(DIMENSION);
  localparam int CW = $clog2(DEPTH) + 1;

  sender_state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [KEY_WIDTH+VW-1:0] head;
  logic [KEY_WIDTH-1:0]    head_key;
  logic [VW-1:0]           head_value;
  logic [PRECISION-1:0]    sel_value;
  logic                    full, empty;
  logic [CW-1:0]           fifo_count;
  logic                    push, pop, last_beat;

  assign push = i_point_valid && !full;

  point_fifo #(
    .WIDTH (KEY_WIDTH + VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (push),
    .i_data  ({i_point_key, i_point_value}),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (fifo_count)
  );

  assign head_key   = head[KEY_WIDTH+VW-1 -: KEY_WIDTH];
  assign head_value = head[VW-1:0];
  assign last_beat  = (beat_q == BW'(DIMENSION - 1));

  // Leaving IDLE on the push itself gives a one-cycle push-to-request.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (push || !empty) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_acknowledged) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        beat_d  = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (last_beat) begin
          pop     = 1'b1;
          beat_d  = '0;
          state_d = (fifo_count > CW'(1) || push) ? ST_REQ : ST_IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    sel_value = '0;
    for (int d = 0; d < DIMENSION; d++) begin
      if (beat_q == BW'(d)) sel_value = head_value[d*PRECISION +: PRECISION];
    end
  end

  assign o_point_ready = !full;
  assign o_count       = fifo_count;
  assign o_request     = (state_q == ST_REQ);
  assign o_busy        = (state_q == ST_WAIT) || (state_q == ST_SEND);
  assign o_key_data    = (state_q == ST_IDLE) ? '0 : head_key;
  assign o_value_data  = (state_q == ST_SEND) ? sel_value : '0;

endmodule

// File: tb/tb_partition_sender.sv
// Self-checking bench for partition_sender.
// Directed scenarios plus random traffic against a queue-based model.
module tb_partition_sender;

  localparam int P = 16;
  localparam int D = 2;
  localparam int N = 4;

  logic          clock;
  logic          reset;
  logic          i_point_valid;
  logic          o_point_ready;
  logic [15:0]   i_point_key;
  logic [P*D-1:0] i_point_value;
  logic          o_request;
  logic          i_acknowledged;
  logic [15:0]   o_key_data;
  logic [P-1:0]  o_value_data;
  logic [2:0]    o_count;
  logic          o_busy;

  partition_sender #(
    .PRECISION (P),
    .DIMENSION (D),
    .DEPTH     (N)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_point_valid  (i_point_valid),
    .o_point_ready  (o_point_ready),
    .i_point_key    (i_point_key),
    .i_point_value  (i_point_value),
    .o_request      (o_request),
    .i_acknowledged (i_acknowledged),
    .o_key_data     (o_key_data),
    .o_value_data   (o_value_data),
    .o_count        (o_count),
    .o_busy         (o_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0]    key;
    logic [P*D-1:0] val;
  } pt_t;

  pt_t q[$];
  // 0: not transmitting; 1: cycle after ack; 2+d: dimension d on lane
  int  phase;
  int  n_cmp;
  int  n_err;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] k,
                      input logic [P*D-1:0] val, input logic a,
                      input logic r);
    int          sz;
    logic [15:0] ek;
    logic [P-1:0] ev;
    logic [P*D-1:0] hv;
    bit          psh;
    i_point_valid  = v;
    i_point_key    = k;
    i_point_value  = val;
    i_acknowledged = a;
    reset          = r;
    sz = q.size();
    ek = (sz > 0) ? q[0].key : 16'h0;
    ev = '0;
    if (phase >= 2) begin
      hv = q[0].val;
      ev = hv[(phase-2)*P +: P];
    end
    check("count", 32'(o_count), 32'(sz));
    check("ready", 32'(o_point_ready), 32'(sz < N));
    check("request", 32'(o_request), 32'(phase == 0 && sz > 0));
    check("busy", 32'(o_busy), 32'(phase > 0));
    check("key", 32'(o_key_data), 32'(ek));
    check("value", 32'(o_value_data), 32'(ev));
    @(posedge clock);
    if (r) begin
      q.delete();
      phase = 0;
    end else begin
      psh = v && (sz < N);
      if (phase == 0) begin
        if (sz > 0 && a) phase = 1;
      end else if (phase == 1 + D) begin
        void'(q.pop_front());
        phase = 0;
      end else begin
        phase++;
      end
      if (psh) q.push_back('{key: k, val: val});
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((o_count != 0 || o_busy) && n < 200) begin
      step(1'b0, 16'h0, '0, o_request, 1'b0);
      n++;
    end
    check("drain_done", 32'(n < 200), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    phase = 0;
    reset = 1'b1;
    i_point_valid  = 1'b0;
    i_point_key    = '0;
    i_point_value  = '0;
    i_acknowledged = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_ready", 32'(o_point_ready), 32'd1);
    check("rst_count", 32'(o_count), 32'd0);

    // spurious ack while idle
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, '0, 1'b1, 1'b0);

    // single point, ack 3 cycles after request rises
    step(1'b1, 16'h0005, {16'hBBBB, 16'hAAAA}, 1'b0, 1'b0);
    check("single_req", 32'(o_request), 32'd1);
    idle(3);
    step(1'b0, 16'h0, '0, 1'b1, 1'b0);
    check("single_req_drop", 32'(o_request), 32'd0);
    check("single_key_wait", 32'(o_key_data), 32'h5);
    idle(1);
    check("single_v0", 32'(o_value_data), 32'hAAAA);
    step(1'b0, 16'h0, '0, 1'b1, 1'b0);
    check("single_v1", 32'(o_value_data), 32'hBBBB);
    check("single_key_send", 32'(o_key_data), 32'h5);
    idle(1);
    check("single_empty", 32'(o_count), 32'd0);
    check("single_idle", 32'(o_busy | o_request), 32'd0);

    // back-to-back, ack on first request cycle
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'(16'h10 + i), 32'($urandom), o_request, 1'b0);
    drain();

    // full buffer and rejected fifth point
    for (int i = 0; i < 5; i++)
      step(1'b1, 16'(16'h20 + i), 32'($urandom), 1'b0, 1'b0);
    check("full_count", 32'(o_count), 32'd4);
    check("full_ready", 32'(o_point_ready), 32'd0);
    drain();

    // push on last SEND cycle with two points held
    step(1'b1, 16'h0031, 32'h11112222, 1'b0, 1'b0);
    step(1'b1, 16'h0032, 32'h33334444, 1'b1, 1'b0);
    while (phase != 1 + D) step(1'b0, 16'h0, '0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 32'h55556666, 1'b1, 1'b0);
    check("pushpop_count", 32'(o_count), 32'd2);
    drain();

    // reset at SEND beat 0
    step(1'b1, 16'h0041, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b0, 16'h0, '0, 1'b1, 1'b0);
    step(1'b0, 16'h0, '0, 1'b0, 1'b0);
    check("pre_rst_v0", 32'(o_value_data), 32'hBEEF);
    step(1'b0, 16'h0, '0, 1'b0, 1'b1);
    check("midrst_value", 32'(o_value_data), 32'd0);
    check("midrst_key", 32'(o_key_data), 32'd0);
    check("midrst_ready", 32'(o_point_ready), 32'd1);
    check("midrst_count", 32'(o_count), 32'd0);
    step(1'b1, 16'h0042, 32'hCAFEF00D, 1'b0, 1'b0);
    drain();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 32'($urandom),
           1'($urandom % 3 == 0), 1'($urandom % 100 == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/partition_sender.md
# partition_sender

Partitioner-side transmit controller for the reduce crossbar. Buffers complete `<key, value>` data points from one partitioner and raises a request toward a reduce arbiter. When that request is acknowledged, it serialises the DIMENSION-word value onto the PRECISION-wide crossbar lane, one dimension per cycle. One instance sits between each partitioner and its crossbar input.

## Interface
Parameters:
- PRECISION, 16, width of one value dimension
- DIMENSION, 2, dimensions per data point (>=1)
- DEPTH, 4, point buffer entries (power of 2, >=2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_point_valid  in  1  partitioner offers a point
- o_point_ready  out  1  buffer can accept (= buffer not full)
- i_point_key  in  16  key of offered point
- i_point_value  in  PRECISION*DIMENSION  value; dimension d at bits [(d+1)*PRECISION-1 -: PRECISION]
- o_request  out  1  request to reduce arbiter
- i_acknowledged  in  1  this sender's grant bit from the reduce arbiter
- o_key_data  out  16  key of head point
- o_value_data  out  PRECISION  current dimension word on the crossbar lane
- o_count  out  $clog2(DEPTH)+1  points held, including the one in transmission
- o_busy  out  1  high in WAIT or SEND

## Operation
- Push: a point is written when i_point_valid && o_point_ready.
  - No bypass: a point written in cycle t is first eligible to request at t+1.
- FSM states:
  - IDLE: buffer empty; o_request=0.
  - REQ: head valid; o_request=1; waits for i_acknowledged.
  - WAIT: one cycle, o_request=0.
  - SEND: DIMENSION cycles; beat counter b runs 0..DIMENSION-1.
- Transitions:
  - IDLE->REQ when count becomes nonzero.
  - REQ->WAIT on i_acknowledged=1.
  - WAIT->SEND unconditionally.
  - SEND at b=DIMENSION-1: pop the head, then ->REQ if another point remains, else ->IDLE.
- i_acknowledged is ignored outside REQ.
- o_value_data:
  - In SEND, it carries dimension b of the head point.
  - In all other states it is 0.
- o_key_data carries the head key in REQ/WAIT/SEND and is 0 in IDLE.
- Push and pop in the same cycle: count is unchanged, and both take effect.
- When full, o_point_ready=0. A pop in that cycle does not raise o_point_ready until the next cycle, because ready comes from the registered count.
- Pointers wrap modulo DEPTH. The beat counter is $clog2(DIMENSION)+1 bits wide and is cleared on leaving SEND.
- For DIMENSION=1, SEND lasts exactly one cycle.

## Timing
- Reset (any cycle, including mid-SEND):
  - Next cycle: state IDLE, count=0, pointers=0, o_request=0, o_value_data=0, o_key_data=0, o_busy=0, o_point_ready=1.
  - Any in-flight point is discarded.
- o_request is registered (decoded from the state register).
- Transmission timing, with acknowledge sampled in cycle A:
  - o_request=0 from cycle A+1.
  - Dimension d is on o_value_data in cycle A+2+d.
  - The head is popped at the end of cycle A+1+DIMENSION.
- Re-request: earliest o_request=1 for the next point is cycle A+2+DIMENSION. Per-point throughput is therefore 2+DIMENSION cycles plus arbitration wait.
- Push-to-request latency into an empty buffer is 1 cycle.
- o_key_data is stable from the first REQ cycle through the last SEND cycle.

## Structure
- Shared package `mapreduce_pkg`:
  - KEY_WIDTH=16
  - Sender state encoding: IDLE, REQ, WAIT, SEND
  - Helper function giving the counter width from DIMENSION
- Sub-module `point_fifo`: synchronous FIFO, DEPTH entries × (16+PRECISION*DIMENSION) bits.
  - Read data is combinational from the head.
  - Exposes full, empty and count.
- partition_sender holds the FSM, the beat counter and the dimension-select mux.

## Test plan
- Single point, DIMENSION=2, PRECISION=16: push key 0x0005, value {0xBBBB, 0xAAAA}; ack 3 cycles after the request rises -> o_request drops at A+1, o_value_data=0xAAAA at A+2 and 0xBBBB at A+3, o_key_data=0x0005 throughout, count returns to 0, state IDLE.
- Back-to-back: push 3 points, ack each on its first request cycle -> each point occupies exactly 4 cycles from ack to re-request, and words appear in push order with no gaps beyond WAIT.
- Full buffer: push 4 points with ack held low -> o_point_ready=0 and count=4; a 5th offered point is not accepted. Then ack -> o_point_ready returns to 1 the cycle after the pop.
- Simultaneous push and pop: with count=2, push on the last SEND cycle -> count stays 2 and the new point is sent third.
- Spurious ack: i_acknowledged=1 in IDLE and during SEND -> no state change and no extra pop.
- Reset mid-SEND at beat 0 -> next cycle all outputs 0, o_point_ready=1, count=0; a new push is then sent correctly.
